// File: rtl/adj_button_conditioner.sv
// Adjust-button conditioner: sync, debounce, press pulse, optional auto-repeat.
// Define AUTO_REPEAT_EN to build the hold-to-repeat FSM per channel.
module adj_button_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter int CNT_W           = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] adj_pulse
);

  localparam int MAX_A =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC =
    (MAX_A > REPEAT_PERIOD) ?
    MAX_A : REPEAT_PERIOD;
  localparam longint CNT_LIM =
    longint'(1) << CNT_W;

  localparam logic [CNT_W-1:0] DEB_TC =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((longint'(MAX_CYC) - 1) >= CNT_LIM
      || DEBOUNCE_CYCLES < 2
      || REPEAT_DELAY < 2
      || REPEAT_PERIOD < 2) begin : g_bad_cfg
    $error("adj_button_conditioner: bad counter config");
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_TC =
    CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_TC =
    CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] deb_cnt;
    logic             flip;
    logic             rise;
    logic             lvl_nxt;
    logic             pulse_nxt;
    logic             pulse_q;

    assign flip    = (s2 != lvl) && (deb_cnt == DEB_TC);
    assign rise    = flip && !lvl;
    assign lvl_nxt = lvl ^ flip;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn_raw[i];
        s2 <= s1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_cnt <= '0;
        lvl     <= 1'b0;
      end else if (s2 == lvl) begin
        deb_cnt <= '0;
      end else if (flip) begin
        deb_cnt <= '0;
        lvl     <= ~lvl;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end

`ifdef AUTO_REPEAT_EN
    rep_state_e       state;
    rep_state_e       state_nxt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             rep_hit;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= ST_IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // A release on this edge overrides any terminal count.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      if (!lvl_nxt) begin
        state_nxt = ST_IDLE;
        rcnt_nxt  = '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (rise) begin
              state_nxt = ST_DELAY;
              rcnt_nxt  = '0;
            end
          end
          ST_DELAY: begin
            if (rcnt == DLY_TC) begin
              state_nxt = ST_REPEAT;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rcnt == PER_TC) begin
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + CNT_W'(1);
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
          end
        endcase
      end
    end

    always_comb begin
      rep_hit = 1'b0;
      if (lvl_nxt) begin
        unique case (1'b1)
          (state == ST_DELAY):
            rep_hit = (rcnt == DLY_TC);
          (state == ST_REPEAT):
            rep_hit = (rcnt == PER_TC);
          default:
            rep_hit = 1'b0;
        endcase
      end
      pulse_nxt = rise | rep_hit;
    end
`else
    assign pulse_nxt = rise;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= pulse_nxt;
      end
    end

    assign btn_level[i] = lvl;
    assign adj_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Directed bench for adj_button_conditioner (D=4, delay=10, period=3).
// Repeat expectations follow AUTO_REPEAT_EN.
module tb_adj_button_conditioner;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] adj_pulse;

  int checks;
  int errors;

  adj_button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .adj_pulse(adj_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_raw = '0;
    for (int k = 0; k < 20; k++) tick();
    chk("settle_lvl", 32'(btn_level), 32'd0);
  endtask

  // Press rises before edge 0, held for 'hold' edges.
  task automatic hold_test(
    input int    ch,
    input int    hold,
    input int    n,
    input string tag
  );
    logic [NB-1:0] m;
    logic          lv;
    logic          pu;
    m = NB'(1) << ch;
    btn_raw = m;
    for (int e = 0; e < n; e++) begin
      if (e == hold) btn_raw = '0;
      tick();
      lv = (hold >= DEB) && (e >= DEB + 1)
           && (e < hold + DEB + 1);
      pu = lv && ((e == DEB + 1) ||
           (AUTO && e >= DEB + 1 + DLY &&
            ((e - (DEB + 1 + DLY)) % PER) == 0));
      chk({tag, "_lvl"}, 32'(btn_level),
          lv ? 32'(m) : 32'd0);
      chk({tag, "_pls"}, 32'(adj_pulse),
          pu ? 32'(m) : 32'd0);
    end
    settle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    btn_raw = '1;

    // held through reset: silent, then a fresh press
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_lvl", 32'(btn_level), 32'd0);
      chk("rst_pls", 32'(adj_pulse), 32'd0);
    end
    reset_n = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      chk("rel_pls", 32'(adj_pulse),
          (e == 5) ? 32'h7 : 32'h0);
      chk("rel_lvl", 32'(btn_level),
          (e >= 5) ? 32'h7 : 32'h0);
    end
    settle();

    hold_test(0, 8, 20, "clean0");
    hold_test(1, 3, 12, "glitch1");
    hold_test(1, 4, 14, "min1");
    // level falls on a repeat terminal edge (edge 45)
    hold_test(2, 40, 56, "hold2");
    hold_test(2, 12, 24, "again2");

    // async reset in the middle of the delay phase
    btn_raw = 3'b001;
    for (int k = 0; k < 8; k++) tick();
    chk("pre_rst_lvl", 32'(btn_level), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_lvl", 32'(btn_level), 32'h0);
    chk("async_pls", 32'(adj_pulse), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("in_rst_pls", 32'(adj_pulse), 32'h0);
    end
    reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("re_pls", 32'(adj_pulse),
          (e == 5) ? 32'h1 : 32'h0);
      chk("re_lvl", 32'(btn_level),
          (e >= 5) ? 32'h1 : 32'h0);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
